compser_ctrl: RTL and testbench

- Sequencer that compares two WIDTH-bit unsigned operands by time-sharing a single 1-bit full comparator (compfull1b).
- Operands are compared one bit pair per cycle, MSB first.
- Uses a start/busy/done handshake; result flags are registered and held.
- Sits between operand producers and downstream logic that needs a magnitude decision at minimum area cost.

---
 rtl/compser_ctrl_pkg.sv | 21 ++
 rtl/compser_ctrl_if.sv | 31 +++
 rtl/compfull1b.sv | 19 +
 rtl/compser_ctrl.sv | 127 ++++++++++++
 tb/tb_compser_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/compser_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// compser_ctrl_pkg
// Shared encodings for the serial magnitude comparator sequencer.
//   state_t : sequencer states (IDLE / RUN / DONE)
//   dec_t   : running magnitude decision (EQ / LT / GT)
// -----------------------------------------------------------------------------
package compser_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DEC_EQ = 2'd0,
        DEC_LT = 2'd1,
        DEC_GT = 2'd2
    } dec_t;

endpackage : compser_ctrl_pkg

// File: rtl/compser_ctrl_if.sv
// -----------------------------------------------------------------------------
// compser_ctrl_if
// Handshake and operand/result bundle for compser_ctrl.
//   start           : request a comparison (producer -> comparator)
//   a, b            : WIDTH-bit unsigned operands (producer -> comparator)
//   busy, done      : sequencer status (comparator -> producer)
//   a_eq_b/lt/gt    : registered, held result flags (comparator -> producer)
// Modports: master = operand producer, slave = compser_ctrl.
// -----------------------------------------------------------------------------
interface compser_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             a_gt_b;

    modport master (
        output start, a, b,
        input  busy, done, a_eq_b, a_lt_b, a_gt_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_eq_b, a_lt_b, a_gt_b
    );
endinterface : compser_ctrl_if

// File: rtl/compfull1b.sv
// -----------------------------------------------------------------------------
// compfull1b
// Single-bit full magnitude comparator; purely combinational.
//   a, b : input bits
//   eq   : a == b
//   lt   : a <  b
//   gt   : a >  b
// -----------------------------------------------------------------------------
module compfull1b (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic lt,
    output logic gt
);
    assign eq = ~(a ^ b);
    assign lt = ~a & b;
    assign gt = a & ~b;
endmodule : compfull1b

// File: rtl/compser_ctrl.sv
// -----------------------------------------------------------------------------
// compser_ctrl
// Compares two WIDTH-bit unsigned operands MSB first, one bit pair per cycle,
// through a single compfull1b. The first differing bit pair fixes the result.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (aborts any operation, clears flags)
//   bus  : compser_ctrl_if.slave -- start/a/b in, busy/done/a_eq_b/a_lt_b/a_gt_b out
//
// Timing: start accepted at edge T -> done pulses in the cycle after edge
// T+WIDTH. busy covers RUN and DONE; flags change only when done rises.
//
// Build option:
//   COMPSER_EARLY_EXIT_EN : when defined, the operation ends right after the
//   first differing bit pair; equal operands still take the full WIDTH cycles.
// -----------------------------------------------------------------------------
module compser_ctrl
    import compser_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    compser_ctrl_if.slave bus
);

    state_t           state;
    dec_t             dec;
    dec_t             dec_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [IDX_W-1:0] idx;
    logic             finish;

    logic busy_q, done_q, eq_q, lt_q, gt_q;
    logic bit_eq, bit_lt, bit_gt;

    // Bit-level datapath: always looks at the current MSB of the shifters.
    compfull1b u_bit (
        .a  (sh_a[WIDTH-1]),
        .b  (sh_b[WIDTH-1]),
        .eq (bit_eq),
        .lt (bit_lt),
        .gt (bit_gt)
    );

    // Decision is sticky: only an EQ decision can be refined by a lower bit.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (avoids a latch).
        dec_nxt = dec;
        if (dec == DEC_EQ && !bit_eq) begin
            if (bit_gt)      dec_nxt = DEC_GT;
            else if (bit_lt) dec_nxt = DEC_LT;
        end
    end

`ifdef COMPSER_EARLY_EXIT_EN
    assign finish = (idx == '0) || (dec == DEC_EQ && dec_nxt != DEC_EQ);
`else
    assign finish = (idx == '0);
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: these are plain registers, not a memory array, so clearing them all on reset is cheap.
            state  <= ST_IDLE;
            dec    <= DEC_EQ;
            sh_a   <= '0;
            sh_b   <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        sh_a   <= bus.a;
                        sh_b   <= bus.b;
                        idx    <= IDX_W'(WIDTH - 1);
                        dec    <= DEC_EQ;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    dec  <= dec_nxt;
                    sh_a <= {sh_a[WIDTH-2:0], 1'b0};
                    sh_b <= {sh_b[WIDTH-2:0], 1'b0};
                    idx  <= idx - IDX_W'(1);
                    if (finish) begin
                        // Flags take the final decision, including the bit
                        // being resolved on this very edge.
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        eq_q   <= (dec_nxt == DEC_EQ);
                        lt_q   <= (dec_nxt == DEC_LT);
                        gt_q   <= (dec_nxt == DEC_GT);
                    end
                end
                ST_DONE: begin
                    // start is ignored here; earliest accept is next IDLE cycle.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.a_eq_b = eq_q;
    assign bus.a_lt_b = lt_q;
    assign bus.a_gt_b = gt_q;

endmodule : compser_ctrl

// File: tb/tb_compser_ctrl.sv
// -----------------------------------------------------------------------------
// tb_compser_ctrl
// Self-checking bench for compser_ctrl (WIDTH=8). Table of operand pairs with
// hand-computed flags and latencies for both builds, plus directed sequences
// for reset, protocol (ignored starts) and mid-operation abort.
// Flags are packed as {a_eq_b, a_lt_b, a_gt_b}.
// -----------------------------------------------------------------------------
module tb_compser_ctrl;

    localparam int WIDTH = 8;

`ifdef COMPSER_EARLY_EXIT_EN
    localparam bit EARLY     = 1'b1;
    localparam int ABORT_DLY = 1;
`else
    localparam bit EARLY     = 1'b0;
    localparam int ABORT_DLY = 4;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    compser_ctrl_if #(.WIDTH(WIDTH)) bus ();

    compser_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_seen++;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] flags;
        int         lat_full;
        int         lat_early;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] flags_now();
        return {bus.a_eq_b, bus.a_lt_b, bus.a_gt_b};
    endfunction

    // Start one operation and return cycles from the start cycle to done
    // (-1 if done never arrives). Operands are inverted right after capture,
    // which must not affect the result. Returns at the negedge of the done cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) begin
                bus.start = 1'b0;
                bus.a     = ~a;
                bus.b     = ~b;
                check("busy_after_accept", 32'(bus.busy), 32'd1);
            end
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int d0;
        int exp_lat;

        vecs[0] = '{8'hA5, 8'h5A, 3'b001, 9, 2};
        vecs[1] = '{8'h40, 8'h41, 3'b010, 9, 9};
        vecs[2] = '{8'hFF, 8'hFF, 3'b100, 9, 9};
        vecs[3] = '{8'h00, 8'h00, 3'b100, 9, 9};
        vecs[4] = '{8'h01, 8'h80, 3'b010, 9, 2};
        vecs[5] = '{8'h7F, 8'h7E, 3'b001, 9, 9};
        vecs[6] = '{8'h3C, 8'h34, 3'b001, 9, 6};
        vecs[7] = '{8'h10, 8'h20, 3'b010, 9, 4};

        // ---------------- reset ----------------
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy",  32'(bus.busy),  32'd0);
        check("reset_done",  32'(bus.done),  32'd0);
        check("reset_flags", 32'(flags_now()), 32'd0);

        // rst and start together: rst wins.
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h00;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("rst_beats_start_busy", 32'(bus.busy), 32'd0);

        d0 = done_seen;
        repeat (20) @(negedge clk);
        check("idle_no_done", 32'(done_seen - d0), 32'd0);
        check("idle_flags",   32'(flags_now()), 32'd0);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            exp_lat = EARLY ? vecs[i].lat_early : vecs[i].lat_full;
            run_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("v%0d_flags", i), 32'(flags_now()), 32'(vecs[i].flags));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'({bus.done, bus.busy}), 32'd0);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_flags_hold", i), 32'(flags_now()), 32'(vecs[i].flags));
        end

        // ---------------- protocol: ignored starts ----------------
        d0 = done_seen;
        @(negedge clk);
        bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40 && bus.done !== 1'b1; i++) @(negedge clk);
        check("proto_done_seen", 32'(bus.done), 32'd1);
        // Hold start high through the DONE cycle's closing edge.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("proto_flags", 32'(flags_now()), 32'b010);
        repeat (20) @(negedge clk);
        check("proto_one_done", 32'(done_seen - d0), 32'd1);
        check("proto_idle_busy", 32'(bus.busy), 32'd0);
        check("proto_flags_hold", 32'(flags_now()), 32'b010);

        // ---------------- abort ----------------
        @(negedge clk);
        bus.a = 8'h80; bus.b = 8'h7F; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        d0 = done_seen;
        repeat (ABORT_DLY - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",  32'(bus.busy), 32'd0);
        check("abort_flags", 32'(flags_now()), 32'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        check("abort_flags_hold", 32'(flags_now()), 32'd0);

        run_op(8'h01, 8'h02, lat);
        check("post_abort_latency", 32'(lat), EARLY ? 32'd8 : 32'd9);
        check("post_abort_flags", 32'(flags_now()), 32'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_compser_ctrl
